mem_fifo_ctrl: RTL
==================

Name: mem_fifo_ctrl

Overview:
FIFO controller that drives a two-port memory wrapper as its initiator. It issues writes and reads on the wrapper's waddr/raddr/wdata/wr/rd pins and absorbs the wrapper's fixed read pipeline latency. Return data is held in a small credit-managed output buffer. It presents valid/ready push and pop interfaces to the client. One instance sits next to each FIFO-style memory wrapper (rx_fifo, wt_fifo class).

Parameters:
WIDTH, 6, data width; must equal the wrapper's width
DEPTH, 512, memory entries; any value >= 2, not required to be a power of 2 (e.g. 46)
ADDR_WIDTH, $clog2(DEPTH), memory address width
RD_LATENCY, 2, cycles from wrapper rd sampled to rdata valid (wrapper out pipes)
OBUF_DEPTH, RD_LATENCY+1, output buffer entries
CNT_WIDTH, $clog2(DEPTH+OBUF_DEPTH+1), occupancy counter width

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
push_valid  input  1  client write request
push_ready  output  1  controller can accept push
push_data  input  WIDTH  write data
pop_valid  output  1  pop_data valid
pop_ready  input  1  client accepts pop_data
pop_data  output  WIDTH  head-of-FIFO data
mem_wr  output  1  to wrapper wr
mem_waddr  output  ADDR_WIDTH  to wrapper waddr
mem_wdata  output  WIDTH  to wrapper wdata
mem_rd  output  1  to wrapper rd
mem_raddr  output  ADDR_WIDTH  to wrapper raddr
mem_rdata  input  WIDTH  from wrapper rdata
count  output  CNT_WIDTH  total entries held (memory + in flight + output buffer)

Behaviour:
- Reset: clk and rst only, rst synchronous active-high. All pointers, counters, in-flight shift register and output buffer clear. Outputs after reset: push_ready=1, pop_valid=0, mem_wr=0, mem_rd=0, count=0, addresses 0.
- Push path:
  - push_fire = push_valid & push_ready.
  - mem_wr = push_fire (combinational), mem_waddr = wptr, mem_wdata = push_data.
  - wptr increments on fire and wraps DEPTH-1 -> 0.
- Memory occupancy mem_occ (registered): +1 on push_fire, -1 on mem_rd, both on the same cycle leaves it unchanged. push_ready = (mem_occ != DEPTH).
- Read issue: mem_rd = (mem_occ != 0) & (inflight + obuf_occ - pop_fire < OBUF_DEPTH).
  - The path from pop_ready to mem_rd is combinational.
  - mem_raddr = rptr; rptr wraps DEPTH-1 -> 0.
  - mem_occ is registered, so an entry is never read in the cycle it is written; no read-during-write on the same address.
- In-flight tracking: a RD_LATENCY-deep valid shift register, fed by mem_rd. When its output is 1, mem_rdata is captured into the output buffer at the end of that cycle. inflight = popcount of the shift register.
- Output buffer: OBUF_DEPTH-entry circular FIFO.
  - pop_valid = (obuf_occ != 0); pop_data = head entry (registered).
  - pop_fire = pop_valid & pop_ready.
  - Capture and pop in the same cycle are both honoured.
  - The credit rule guarantees the buffer never overflows; an overflow is an assertion failure.
- Latency (RD_LATENCY=2, empty FIFO):
  - push at cycle 0
  - mem_rd at cycle 1
  - mem_rdata valid at cycle 3
  - pop_valid at cycle 4
- Throughput: one push and one pop per cycle sustained.
- count = mem_occ + inflight + obuf_occ, registered. Maximum value is DEPTH+OBUF_DEPTH.
- push_ready deasserts only when memory is full. Total capacity is DEPTH+OBUF_DEPTH.
- Reset mid-operation:
  - Data returning from the wrapper after rst is discarded, because the shift register is cleared.
  - No mem_wr or mem_rd is driven during the rst cycle.
- Data order is strictly FIFO across pointer wrap.

Test Plan:
- Single entry: reset, push 0x2A at cycle 0 -> mem_wr=1 with waddr=0 at cycle 0; mem_rd with raddr=0 at cycle 1; pop_valid=1 with pop_data=0x2A at cycle 4; count goes 0,1,1,1,1, then 0 after the pop.
- Fill with pop_ready=0, DEPTH=46: push 0..55 -> the first 3 entries land in obuf, memory fills; push_ready=0 after 49 accepted; count=49. Then pop all -> values 0..48 in order, no gaps.
- Streaming: push_valid=1 and pop_ready=1 continuously for 1000 cycles, DEPTH=46 -> after a 4-cycle fill, pop_fire every cycle, data in order, pointers wrap 45->0 repeatedly.
- Backpressure toggle: pop_ready random 50% during streaming -> mem_rd never issued when obuf_occ+inflight-pop_fire=3; no obuf overflow assertion; scoreboard matches.
- Reset mid-flight: with 2 reads in flight and obuf_occ=1, assert rst for 1 cycle -> next cycle pop_valid=0, count=0, push_ready=1; returning mem_rdata is not captured; a subsequent push/pop of 0x15 returns 0x15.
- Simultaneous push/pop at full: mem_occ=DEPTH and pop_fire in the same cycle -> push_ready stays 0 that cycle; mem_rd fires, mem_occ drops to DEPTH-1, and push_ready=1 the next cycle.

Source files
------------

// File: rtl/mem_fifo_ctrl.sv
// rtl/mem_fifo_ctrl.sv - FIFO controller driving a two-port memory wrapper with a credit-managed output buffer
//
// Purpose: accepts client pushes into an external two-port memory, issues reads
// ahead of the client, absorbs the wrapper's fixed read latency and holds the
// returned words in a small output buffer sized so it can never overflow.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   push_valid/push_ready/push_data   client write interface
//   pop_valid/pop_ready/pop_data      client read interface (head of FIFO)
//   mem_wr/mem_waddr/mem_wdata        wrapper write port
//   mem_rd/mem_raddr/mem_rdata        wrapper read port (rdata RD_LATENCY cycles after rd)
//   count                             entries held: memory + in flight + output buffer
module mem_fifo_ctrl #(
  parameter int WIDTH      = 6,
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int RD_LATENCY = 2,
  parameter int OBUF_DEPTH = RD_LATENCY + 1,
  parameter int CNT_WIDTH  = $clog2(DEPTH + OBUF_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [WIDTH-1:0]      push_data,
  output logic                  pop_valid,
  input  logic                  pop_ready,
  output logic [WIDTH-1:0]      pop_data,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [WIDTH-1:0]      mem_wdata,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [WIDTH-1:0]      mem_rdata,
  output logic [CNT_WIDTH-1:0]  count
);

  localparam int OB_AW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] LP_ADDR_LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [OB_AW-1:0]      LP_OB_LAST   = OB_AW'(OBUF_DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0]  LP_DEPTH     = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0]  LP_OBUF      = CNT_WIDTH'(OBUF_DEPTH);

  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH-1:0] r_rptr;
  logic [CNT_WIDTH-1:0]  r_mem_occ;
  logic [RD_LATENCY-1:0] r_rd_sr;
  logic [WIDTH-1:0]      r_obuf [OBUF_DEPTH];
  logic [OB_AW-1:0]      r_ob_wptr;
  logic [OB_AW-1:0]      r_ob_rptr;
  logic [CNT_WIDTH-1:0]  r_ob_occ;
  logic [CNT_WIDTH-1:0]  r_count;

  logic                  w_push_fire;
  logic                  w_pop_fire;
  logic                  w_capture;
  logic [CNT_WIDTH-1:0]  w_inflight;
  logic [CNT_WIDTH-1:0]  w_credit;

  assign push_ready  = (r_mem_occ != LP_DEPTH);
  // Gating with rst keeps the wrapper quiet during the reset cycle.
  assign w_push_fire = push_valid & push_ready & ~rst;
  assign mem_wr      = w_push_fire;
  assign mem_waddr   = r_wptr;
  assign mem_wdata   = push_data;

  assign pop_valid   = (r_ob_occ != '0);
  assign pop_data    = r_obuf[r_ob_rptr];
  assign w_pop_fire  = pop_valid & pop_ready;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      w_inflight = w_inflight + CNT_WIDTH'(r_rd_sr[i]);
    end
  end

  // A read is only issued if its word is guaranteed a slot in the output
  // buffer; a pop in this cycle frees a slot, hence the combinational
  // pop_ready -> mem_rd path that keeps one pop per cycle sustainable.
  assign w_credit  = w_inflight + r_ob_occ - CNT_WIDTH'(w_pop_fire);
  assign mem_rd    = ~rst & (r_mem_occ != '0) & (w_credit < LP_OBUF);
  assign mem_raddr = r_rptr;
  assign w_capture = r_rd_sr[RD_LATENCY-1];

  assign count = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_mem_occ <= '0;
      r_rd_sr   <= '0;
      r_ob_wptr <= '0;
      r_ob_rptr <= '0;
      r_ob_occ  <= '0;
      r_count   <= '0;
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        r_obuf[i] <= '0;
      end
    end else begin
      if (w_push_fire) begin
        r_wptr <= (r_wptr == LP_ADDR_LAST) ? '0 : r_wptr + 1'b1;
      end
      if (mem_rd) begin
        r_rptr <= (r_rptr == LP_ADDR_LAST) ? '0 : r_rptr + 1'b1;
      end
      r_mem_occ <= r_mem_occ + CNT_WIDTH'(w_push_fire) - CNT_WIDTH'(mem_rd);

      r_rd_sr[0] <= mem_rd;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_rd_sr[i] <= r_rd_sr[i-1];
      end

      if (w_capture) begin
        r_obuf[r_ob_wptr] <= mem_rdata;
        r_ob_wptr <= (r_ob_wptr == LP_OB_LAST) ? '0 : r_ob_wptr + 1'b1;
      end
      if (w_pop_fire) begin
        r_ob_rptr <= (r_ob_rptr == LP_OB_LAST) ? '0 : r_ob_rptr + 1'b1;
      end
      r_ob_occ <= r_ob_occ + CNT_WIDTH'(w_capture) - CNT_WIDTH'(w_pop_fire);

      // Entries only enter on push and leave on pop; transfers between
      // memory, pipeline and buffer leave the total unchanged.
      r_count <= r_count + CNT_WIDTH'(w_push_fire) - CNT_WIDTH'(w_pop_fire);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_capture && !w_pop_fire) begin
      assert (r_ob_occ < LP_OBUF);
    end
  end

endmodule
